pc_sequencer: RTL and testbench

Program-sequencing controller for the single-issue core. It owns the program counter and the start/done handshake with the test harness. It issues one instruction at a time from the instruction ROM to the decode/control path, stalls multi-cycle loads, applies relative branches and detects the halt encoding. The `IssueEn` output qualifies the decoder's `RegWrite`/`MemWrite` strobes, so no architectural state changes outside an issue cycle. A saturating cycle counter supports benchmark reporting.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-sequencing controller for the single-issue core. Owns the program
//   counter and the Start/Done handshake with the harness. It issues one
//   instruction at a time, stalls multi-cycle loads, applies relative branches,
//   detects the halt encoding and counts executed cycles (saturating).
//
// Ports
//   Clk          in   clock, rising edge
//   Reset_n      in   synchronous active-low reset
//   Start        in   one-cycle pulse, (re)starts execution at PC 0
//   Instr        in   [INSTR_W] instruction at PC (combinational ROM)
//   LdStSel      in   current instruction is a load
//   BranchRel    in   current instruction is a relative branch
//   Taken        in   branch condition from the ALU
//   BranchOffset in   [PC_W] two's-complement PC offset
//   PC           out  [PC_W] registered program counter
//   IssueEn      out  combinational; current instruction completes this cycle
//   Done         out  registered; program halted
//   CycleCount   out  [CNT_W] registered cycles spent in the current/last run
module pc_sequencer #(
   parameter int                 PC_W       = 10,
   parameter int                 INSTR_W    = 9,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
   parameter int                 LD_LAT     = 2,
   parameter int                 CNT_W      = 16
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic [INSTR_W-1:0] Instr,
   input  logic               LdStSel,
   input  logic               BranchRel,
   input  logic               Taken,
   input  logic [PC_W-1:0]    BranchOffset,
   output logic [PC_W-1:0]    PC,
   output logic               IssueEn,
   output logic               Done,
   output logic [CNT_W-1:0]   CycleCount
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   // With LD_LAT == 1 a load is indistinguishable from a single-cycle op.
   localparam bit         LOAD_STALLS = (LD_LAT > 1);
   localparam logic [3:0] WAIT_INIT   = 4'(LD_LAT - 1);

   logic [1:0]       state;
   logic [3:0]       wait_cnt;
   logic [PC_W-1:0]  pc_q;
   logic             done_q;
   logic [CNT_W-1:0] cnt_q;

   logic                   is_halt;
   logic                   load_stall;
   logic                   issue;
   logic signed [PC_W-1:0] offset_s;
   logic [PC_W-1:0]        pc_next;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign is_halt    = (Instr == HALT_INSTR);
   assign load_stall = LdStSel && LOAD_STALLS;
   assign offset_s   = $signed(BranchOffset);

   // Relative target wraps modulo 2^PC_W, as does the sequential increment.
   always_comb begin
      pc_next = pc_q + 1'b1;
      if (BranchRel && Taken)
         pc_next = $unsigned($signed(pc_q) + offset_s);
   end

   // Issue depends only on current state and the instruction in flight,
   // never on Start or Reset_n.
   always_comb begin
      issue = 1'b0;
      case (state)
         S_RUN:   issue = !is_halt && !load_stall;
         S_WAIT:  issue = (wait_cnt == 4'd1);
         default: issue = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         pc_q     <= '0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else if (Start) begin
         // Start aborts whatever is in flight, from any state.
         state    <= S_RUN;
         wait_cnt <= '0;
         pc_q     <= '0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state)
            S_RUN: begin
               cnt_q <= sat_inc(cnt_q);
               if (is_halt) begin
                  state  <= S_HALTED;
                  done_q <= 1'b1;
               end else if (load_stall) begin
                  state    <= S_WAIT;
                  wait_cnt <= WAIT_INIT;
               end else begin
                  pc_q <= pc_next;
               end
            end
            S_WAIT: begin
               cnt_q    <= sat_inc(cnt_q);
               wait_cnt <= wait_cnt - 1'b1;
               if (wait_cnt == 4'd1) begin
                  state <= S_RUN;
                  pc_q  <= pc_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign PC         = pc_q;
   assign IssueEn    = issue;
   assign Done       = done_q;
   assign CycleCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam logic [8:0] HALT = 9'h1FF;

   logic       Clk;
   logic       Reset_n;
   logic       Start;

   logic [8:0] rom_instr [1024];
   logic       rom_ld    [1024];
   logic       rom_br    [1024];
   logic       rom_tk    [1024];
   logic [9:0] rom_off   [1024];

   // main DUT: LD_LAT=3, CNT_W=4
   logic [8:0] instr0;
   logic       ld0, br0, tk0;
   logic [9:0] off0, pc0;
   logic       issue0, done0;
   logic [3:0] cnt0;

   // second DUT: LD_LAT=1
   logic [8:0] instr1;
   logic       ld1, br1, tk1;
   logic [9:0] off1, pc1;
   logic       issue1, done1;
   logic [3:0] cnt1;

   int total = 0;
   int bad   = 0;

   assign instr0 = rom_instr[pc0];
   assign ld0    = rom_ld[pc0];
   assign br0    = rom_br[pc0];
   assign tk0    = rom_tk[pc0];
   assign off0   = rom_off[pc0];

   assign instr1 = rom_instr[pc1];
   assign ld1    = rom_ld[pc1];
   assign br1    = rom_br[pc1];
   assign tk1    = rom_tk[pc1];
   assign off1   = rom_off[pc1];

   pc_sequencer #(.PC_W(10), .INSTR_W(9), .HALT_INSTR(HALT), .LD_LAT(3), .CNT_W(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instr(instr0), .LdStSel(ld0),
      .BranchRel(br0), .Taken(tk0), .BranchOffset(off0), .PC(pc0), .IssueEn(issue0),
      .Done(done0), .CycleCount(cnt0)
   );

   pc_sequencer #(.PC_W(10), .INSTR_W(9), .HALT_INSTR(HALT), .LD_LAT(1), .CNT_W(4)) dut1 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instr(instr1), .LdStSel(ld1),
      .BranchRel(br1), .Taken(tk1), .BranchOffset(off1), .PC(pc1), .IssueEn(issue1),
      .Done(done1), .CycleCount(cnt1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 1024; i++) begin
         rom_instr[i] = 9'h000;
         rom_ld[i]    = 1'b0;
         rom_br[i]    = 1'b0;
         rom_tk[i]    = 1'b0;
         rom_off[i]   = 10'h000;
      end
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      step(1);
      Start = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      Start   = 1'b0;
      step(2);
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", pc0); end
      total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done0); end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt0); end
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b want=0", issue0); end
      Reset_n = 1'b1;
      step(3);
      // Still idle: an add sits at PC 0 but nothing issues or counts.
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL idle_issue got=%b want=0", issue0); end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL idle_cnt got=%0d want=0", cnt0); end
   endtask

   task automatic test_basic();
      rom_clear();
      rom_instr[0] = 9'h010;
      rom_instr[1] = 9'h020;
      rom_instr[2] = HALT;
      pulse_start();
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL basic_pc0 got=%0d want=0", pc0); end
      total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL basic_issue0 got=%b want=1", issue0); end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL basic_cnt0 got=%0d want=0", cnt0); end
      step(1);
      total++; if (pc0 !== 10'd1) begin bad++; $display("FAIL basic_pc1 got=%0d want=1", pc0); end
      total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL basic_issue1 got=%b want=1", issue0); end
      step(1);
      total++; if (pc0 !== 10'd2) begin bad++; $display("FAIL basic_pc2 got=%0d want=2", pc0); end
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL basic_halt_issue got=%b want=0", issue0); end
      total++; if (done0 !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b want=0", done0); end
      step(1);
      total++; if (done0 !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done0); end
      total++; if (pc0 !== 10'd2) begin bad++; $display("FAIL basic_pc_halt got=%0d want=2", pc0); end
      total++; if (cnt0 !== 4'd3) begin bad++; $display("FAIL basic_cnt got=%0d want=3", cnt0); end
      step(2);
      total++; if (cnt0 !== 4'd3) begin bad++; $display("FAIL basic_cnt_frozen got=%0d want=3", cnt0); end
      total++; if (pc0 !== 10'd2) begin bad++; $display("FAIL basic_pc_frozen got=%0d want=2", pc0); end
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL basic_halted_issue got=%b want=0", issue0); end
   endtask

   task automatic test_load();
      rom_clear();
      rom_instr[0] = 9'h040; rom_ld[0] = 1'b1;
      rom_instr[1] = 9'h010;
      rom_instr[2] = HALT;
      pulse_start();
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL load_c1_issue got=%b want=0", issue0); end
      step(1);
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL load_c2_pc got=%0d want=0", pc0); end
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL load_c2_issue got=%b want=0", issue0); end
      step(1);
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL load_c3_pc got=%0d want=0", pc0); end
      total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL load_c3_issue got=%b want=1", issue0); end
      step(1);
      total++; if (pc0 !== 10'd1) begin bad++; $display("FAIL load_next_pc got=%0d want=1", pc0); end
      total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL load_add_issue got=%b want=1", issue0); end
      step(2);
      total++; if (done0 !== 1'b1) begin bad++; $display("FAIL load_done got=%b want=1", done0); end
      total++; if (cnt0 !== 4'd5) begin bad++; $display("FAIL load_cnt got=%0d want=5", cnt0); end
   endtask

   task automatic test_branch();
      rom_clear();
      rom_br[5] = 1'b1;    rom_tk[5] = 1'b1;    rom_off[5] = 10'h3FD;
      rom_br[6] = 1'b1;    rom_tk[6] = 1'b1;    rom_off[6] = 10'h3F9;
      rom_br[1023] = 1'b1; rom_tk[1023] = 1'b1; rom_off[1023] = 10'h002;
      pulse_start();
      step(5);
      total++; if (pc0 !== 10'd5) begin bad++; $display("FAIL br_reach got=%0d want=5", pc0); end
      total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL br_issue got=%b want=1", issue0); end
      step(1);
      total++; if (pc0 !== 10'd2) begin bad++; $display("FAIL br_back got=%0d want=2", pc0); end
      rom_tk[5] = 1'b0;
      step(4);
      total++; if (pc0 !== 10'd6) begin bad++; $display("FAIL br_not_taken got=%0d want=6", pc0); end
      step(1);
      total++; if (pc0 !== 10'd1023) begin bad++; $display("FAIL br_fwd got=%0d want=1023", pc0); end
      step(1);
      total++; if (pc0 !== 10'd1) begin bad++; $display("FAIL br_wrap got=%0d want=1", pc0); end
   endtask

   task automatic test_wrap();
      rom_clear();
      pulse_start();
      step(14);
      total++; if (cnt0 !== 4'd14) begin bad++; $display("FAIL wrap_cnt14 got=%0d want=14", cnt0); end
      step(1);
      total++; if (cnt0 !== 4'd15) begin bad++; $display("FAIL wrap_cnt15 got=%0d want=15", cnt0); end
      step(1);
      total++; if (cnt0 !== 4'd15) begin bad++; $display("FAIL wrap_sat got=%0d want=15", cnt0); end
      total++; if (pc0 !== 10'd16) begin bad++; $display("FAIL wrap_pc16 got=%0d want=16", pc0); end
      step(1007);
      total++; if (pc0 !== 10'd1023) begin bad++; $display("FAIL wrap_pcmax got=%0d want=1023", pc0); end
      step(1);
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL wrap_pc0 got=%0d want=0", pc0); end
      total++; if (cnt0 !== 4'd15) begin bad++; $display("FAIL wrap_sat_hold got=%0d want=15", cnt0); end
   endtask

   task automatic test_abort();
      rom_clear();
      rom_instr[7] = 9'h040; rom_ld[7] = 1'b1;
      pulse_start();
      step(7);
      total++; if (pc0 !== 10'd7) begin bad++; $display("FAIL abort_pc7 got=%0d want=7", pc0); end
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL abort_ld_issue got=%b want=0", issue0); end
      step(1);
      total++; if (cnt0 !== 4'd8) begin bad++; $display("FAIL abort_cnt8 got=%0d want=8", cnt0); end
      pulse_start();
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL abort_pc got=%0d want=0", pc0); end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL abort_cnt got=%0d want=0", cnt0); end
      total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL abort_run_issue got=%b want=1", issue0); end
      rom_instr[2] = HALT;
      step(1);
      total++; if (pc0 !== 10'd1) begin bad++; $display("FAIL abort_pc1 got=%0d want=1", pc0); end
      step(2);
      total++; if (done0 !== 1'b1) begin bad++; $display("FAIL restart_done got=%b want=1", done0); end
      pulse_start();
      total++; if (done0 !== 1'b0) begin bad++; $display("FAIL restart_done_clr got=%b want=0", done0); end
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL restart_pc got=%0d want=0", pc0); end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL restart_cnt got=%0d want=0", cnt0); end
      total++; if (issue0 !== 1'b1) begin bad++; $display("FAIL restart_issue got=%b want=1", issue0); end
   endtask

   task automatic test_reset_mid();
      rom_clear();
      rom_instr[0] = 9'h040; rom_ld[0] = 1'b1;
      pulse_start();
      step(1);
      total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL rmid_cnt1 got=%0d want=1", cnt0); end
      Reset_n = 1'b0;
      step(1);
      Reset_n = 1'b1;
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL rmid_pc got=%0d want=0", pc0); end
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", cnt0); end
      total++; if (done0 !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", done0); end
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL rmid_issue got=%b want=0", issue0); end
      step(3);
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL rmid_idle_cnt got=%0d want=0", cnt0); end
      total++; if (issue0 !== 1'b0) begin bad++; $display("FAIL rmid_idle_issue got=%b want=0", issue0); end
      Start   = 1'b1;
      Reset_n = 1'b0;
      step(1);
      Start   = 1'b0;
      Reset_n = 1'b1;
      step(2);
      total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL rwin_cnt got=%0d want=0", cnt0); end
      total++; if (pc0 !== 10'd0) begin bad++; $display("FAIL rwin_pc got=%0d want=0", pc0); end
   endtask

   task automatic test_ld_lat1();
      rom_clear();
      rom_instr[0] = 9'h040; rom_ld[0] = 1'b1;
      rom_instr[1] = 9'h010;
      rom_instr[2] = HALT;
      pulse_start();
      total++; if (issue1 !== 1'b1) begin bad++; $display("FAIL lat1_issue got=%b want=1", issue1); end
      step(1);
      total++; if (pc1 !== 10'd1) begin bad++; $display("FAIL lat1_pc1 got=%0d want=1", pc1); end
      step(2);
      total++; if (done1 !== 1'b1) begin bad++; $display("FAIL lat1_done got=%b want=1", done1); end
      total++; if (cnt1 !== 4'd3) begin bad++; $display("FAIL lat1_cnt got=%0d want=3", cnt1); end
   endtask

   initial begin
      Reset_n = 1'b0;
      Start   = 1'b0;
      rom_clear();
      rom_instr[0] = 9'h010;
      test_reset();
      test_basic();
      test_load();
      test_branch();
      test_wrap();
      test_abort();
      test_reset_mid();
      test_ld_lat1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
